// File: rtl/bexkat1_intseq_pkg.sv
// bexkat1Def: shared definitions for the bexkat1 integer sequencer.
//   intfunc_t      : 4-bit integer operation codes (codes 12..15 are unused)
//   intseq_state_t : sequencer FSM states
//   helpers        : operation-class decode functions
package bexkat1Def;

  typedef enum logic [3:0] {
    INT_MUL   = 4'd0,
    INT_DIV   = 4'd1,
    INT_MOD   = 4'd2,
    INT_MULU  = 4'd3,
    INT_DIVU  = 4'd4,
    INT_MODU  = 4'd5,
    INT_MULX  = 4'd6,
    INT_MULUX = 4'd7,
    INT_EXT   = 4'd8,
    INT_EXTB  = 4'd9,
    INT_COM   = 4'd10,
    INT_NEG   = 4'd11
  } intfunc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } intseq_state_t;

  function automatic logic is_mul(intfunc_t f);
    return f inside {INT_MUL, INT_MULU, INT_MULX, INT_MULUX};
  endfunction

  function automatic logic is_div(intfunc_t f);
    return f inside {INT_DIV, INT_DIVU, INT_MOD, INT_MODU};
  endfunction

  function automatic logic is_single(intfunc_t f);
    return f inside {INT_EXT, INT_EXTB, INT_COM, INT_NEG};
  endfunction

  function automatic logic is_signed_op(intfunc_t f);
    return f inside {INT_MUL, INT_MULX, INT_DIV, INT_MOD};
  endfunction

  function automatic logic is_high(intfunc_t f);
    return f inside {INT_MULX, INT_MULUX};
  endfunction

  function automatic logic is_mod(intfunc_t f);
    return f inside {INT_MOD, INT_MODU};
  endfunction

endpackage

// File: rtl/bexkat1_intseq_step.sv
// bexkat1_intseq_step: one combinational iteration of the sequencer datapath.
//   Multiply : if lo[0], hi += opd; then {hi,lo} shifts right by one.
//   Divide   : restoring step; {rem,quo} shifts left, trial-subtract divisor.
// Ports:
//   div_i  : select divide step (only present with BEXKAT1_INTSEQ_DIV_EN)
//   hi_i   : upper accumulator (partial product high / remainder), WIDTH+1 bits
//   lo_i   : lower accumulator (multiplier / dividend-quotient), WIDTH bits
//   opd_i  : multiplicand or divisor magnitude
//   hi_o, lo_o : accumulators after this iteration
// Build option: BEXKAT1_INTSEQ_DIV_EN adds the divide step.
module bexkat1_intseq_step #(
  parameter int WIDTH = 32
) (
`ifdef BEXKAT1_INTSEQ_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH:0]   hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opd_i,
  output logic [WIDTH:0]   hi_o,
  output logic [WIDTH-1:0] lo_o
);

`ifdef BEXKAT1_INTSEQ_DIV_EN
  logic [WIDTH:0]   a;
  logic [WIDTH+1:0] b;
  logic [WIDTH+1:0] sum;

  // Single adder shared by both modes; divide subtracts via ~b + 1.
  always_comb begin
    if (div_i) begin
      a = {hi_i[WIDTH-1:0], lo_i[WIDTH-1]};
      b = ~{2'b00, opd_i};
    end else begin
      a = hi_i;
      b = lo_i[0] ? {2'b00, opd_i} : '0;
    end
    sum = {1'b0, a} + b + {{(WIDTH+1){1'b0}}, div_i};
  end

  always_comb begin
    if (div_i) begin
      // sum[WIDTH+1] set means the trial subtraction went negative: restore.
      if (!sum[WIDTH+1]) begin
        hi_o = sum[WIDTH:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = a;
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_o = {1'b0, sum[WIDTH:1]};
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end
`else
  logic [WIDTH:0] sum;

  always_comb begin
    sum  = hi_i + (lo_i[0] ? {1'b0, opd_i} : '0);
    hi_o = {1'b0, sum[WIDTH:1]};
    lo_o = {sum[0], lo_i[WIDTH-1:1]};
  end
`endif

endmodule

// File: rtl/bexkat1_intseq.sv
// bexkat1_intseq: sequential integer unit (multiply/divide/extend).
// Single-cycle ops finish in the cycle after start; iterative ops take
// WIDTH RUN cycles plus one FIX cycle that applies the result sign.
// Ports:
//   clk_i, rst_i (async, active-high)
//   start_i, func_i, in1_i, in2_i : request, latched when accepted in IDLE
//   out_o, err_o                  : result and error, held until rewritten
//   busy_o                        : state is not IDLE
//   done_o                        : one-cycle result-valid pulse
// Build option: BEXKAT1_INTSEQ_DIV_EN enables DIV/DIVU/MOD/MODU; without it
// those codes report as unsupported.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | one shift-add / shift-subtract step per cycle, counter counts down
// FIX   | apply sign / select result half, write out_o
// DONE  | done_o pulse, start_i ignored
module bexkat1_intseq
  import bexkat1Def::*;
#(
  parameter int WIDTH    = 32,
  parameter bit FAST_EXT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  intfunc_t         func_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  output logic [WIDTH-1:0] out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  intseq_state_t    state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   hi_q;
  logic [WIDTH-1:0] lo_q, opd_q, out_q;
  intfunc_t         func_q;
  logic             neg_q, err_q;

  logic [WIDTH:0]   step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] fix_res;

  logic accept, op_div_ok, op_unsup, op_dz, op_fast, op_sgn;

  function automatic logic [WIDTH-1:0] mag(logic [WIDTH-1:0] x, logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  // Widen to 64 bits so EXT stays well-formed for WIDTH below 16.
  function automatic logic [WIDTH-1:0] ext_res(intfunc_t f, logic [WIDTH-1:0] x);
    logic [63:0] x64, e;
    x64 = 64'(x);
    case (f)
      INT_EXT:  e = {{48{x64[15]}}, x64[15:0]};
      INT_EXTB: e = {{56{x64[7]}}, x64[7:0]};
      INT_COM:  e = ~x64;
      default:  e = -x64;
    endcase
    return e[WIDTH-1:0];
  endfunction

  always_comb begin
    accept = (state_q == IDLE) && start_i;
`ifdef BEXKAT1_INTSEQ_DIV_EN
    op_div_ok = is_div(func_i);
`else
    op_div_ok = 1'b0;
`endif
    op_unsup = !(is_mul(func_i) || is_single(func_i) || op_div_ok);
    op_dz    = op_div_ok && (in2_i == '0);
    op_fast  = FAST_EXT && is_single(func_i);
    op_sgn   = is_signed_op(func_i);
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (op_unsup || op_dz || op_fast) ? DONE : RUN;
      RUN:  if (cnt_q == CW'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = (state_q == DONE);
    out_o  = out_q;
    err_o  = err_q;
  end

  bexkat1_intseq_step #(.WIDTH(WIDTH)) u_step (
`ifdef BEXKAT1_INTSEQ_DIV_EN
    .div_i (is_div(func_q)),
`endif
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .opd_i (opd_q),
    .hi_o  (step_hi),
    .lo_o  (step_lo)
  );

  // Sign fix on the full 2*WIDTH product so MULX gets the correct high half.
  always_comb begin
    logic [2*WIDTH-1:0] prod;
    prod    = {hi_q[WIDTH-1:0], lo_q};
    prod    = neg_q ? -prod : prod;
    fix_res = '0;
    if (is_single(func_q)) begin
      fix_res = ext_res(func_q, lo_q);
    end else if (is_mul(func_q)) begin
      fix_res = is_high(func_q) ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    end
`ifdef BEXKAT1_INTSEQ_DIV_EN
    else begin
      fix_res = is_mod(func_q) ? hi_q[WIDTH-1:0] : lo_q;
      fix_res = neg_q ? -fix_res : fix_res;
    end
`endif
  end

  // Datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opd_q  <= '0;
      out_q  <= '0;
      err_q  <= 1'b0;
      neg_q  <= 1'b0;
      func_q <= INT_MUL;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          func_q <= func_i;
          if (op_unsup) begin
            out_q <= '0;
            err_q <= 1'b1;
          end else if (op_dz) begin
            out_q <= '1;
            err_q <= 1'b1;
          end else if (op_fast) begin
            out_q <= ext_res(func_i, in1_i);
            err_q <= 1'b0;
          end else begin
            cnt_q <= CW'(WIDTH);
            hi_q  <= '0;
            neg_q <= op_sgn && (is_mod(func_i) ? in1_i[WIDTH-1]
                                               : in1_i[WIDTH-1] ^ in2_i[WIDTH-1]);
            if (is_single(func_i)) begin
              lo_q  <= in1_i;
              opd_q <= '0;
            end else if (is_mul(func_i)) begin
              lo_q  <= mag(in2_i, op_sgn);
              opd_q <= mag(in1_i, op_sgn);
            end else begin
              lo_q  <= mag(in1_i, op_sgn);
              opd_q <= mag(in2_i, op_sgn);
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CW'(1);
          if (!is_single(func_q)) begin
            hi_q <= step_hi;
            lo_q <= step_lo;
          end
        end
        FIX: begin
          out_q <= fix_res;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bexkat1_intseq.sv
// Directed bench for bexkat1_intseq (WIDTH=32, FAST_EXT=1).
// Divide expectations depend on BEXKAT1_INTSEQ_DIV_EN: with it undefined the
// divide codes are expected to behave as unsupported.
module tb_bexkat1_intseq;
  import bexkat1Def::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  intfunc_t    func = INT_MUL;
  logic [31:0] in1 = '0, in2 = '0;
  logic [31:0] out;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;
  int lat;
  int pulses;
  logic [31:0] res_at_done;

  bexkat1_intseq #(.WIDTH(32), .FAST_EXT(1'b1)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .func_i  (func),
    .in1_i   (in1),
    .in2_i   (in2),
    .out_o   (out),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one op and waits (bounded) for done; lat=0 means it never came.
  // Inputs are scrambled after the start edge to exercise operand latching.
  task automatic do_op(input intfunc_t f, input logic [31:0] a, input logic [31:0] b,
                       output int l);
    @(negedge clk);
    func = f; in1 = a; in2 = b; start = 1'b1;
    @(posedge clk);
    l = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      start = 1'b0; in1 = 32'hDEADBEEF; in2 = 32'h0; func = INT_COM;
      if (done) begin
        l = n;
        break;
      end
    end
  endtask

  task automatic op_chk(input string tag, input intfunc_t f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_out, input logic exp_err);
    int l;
    do_op(f, a, b, l);
    chk({tag, "_lat"}, 64'(l), 64'(exp_lat));
    chk({tag, "_out"}, 64'(out), 64'(exp_out));
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out",  64'(out),  64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_err",  64'(err),  64'h0);
    rst = 1'b0;

    // Multiply
    op_chk("mul_7_m3",   INT_MUL,   32'h7,        32'hFFFFFFFD, 34, 32'hFFFFFFEB, 1'b0);
    op_chk("mulux_ff",   INT_MULUX, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 1'b0);
    op_chk("mulx_ff",    INT_MULX,  32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'h00000000, 1'b0);
    op_chk("mulu_shift", INT_MULU,  32'h12345678, 32'h00000010, 34, 32'h23456780, 1'b0);
    op_chk("mul_wrap",   INT_MUL,   32'h00010000, 32'h00010000, 34, 32'h00000000, 1'b0);
    op_chk("mulx_m2_3",  INT_MULX,  32'hFFFFFFFE, 32'h00000003, 34, 32'hFFFFFFFF, 1'b0);

    // Single-cycle ops
    op_chk("extb_80",  INT_EXTB, 32'h00000080, 32'h0, 1, 32'hFFFFFF80, 1'b0);
    op_chk("ext_8000", INT_EXT,  32'h00018000, 32'h0, 1, 32'hFFFF8000, 1'b0);
    op_chk("com",      INT_COM,  32'h0F0F0000, 32'h0, 1, 32'hF0F0FFFF, 1'b0);
    op_chk("neg_1",    INT_NEG,  32'h00000001, 32'h0, 1, 32'hFFFFFFFF, 1'b0);
    op_chk("neg_0",    INT_NEG,  32'h00000000, 32'h0, 1, 32'h00000000, 1'b0);

    // Unsupported code, then error cleared by a good op
    op_chk("unsup_13", intfunc_t'(4'd13), 32'h5, 32'h3, 1, 32'h0, 1'b1);
    op_chk("after_unsup", INT_EXTB, 32'h0000007F, 32'h0, 1, 32'h0000007F, 1'b0);

`ifdef BEXKAT1_INTSEQ_DIV_EN
    op_chk("div_m7_2",   INT_DIV,  32'hFFFFFFF9, 32'h2,        34, 32'hFFFFFFFD, 1'b0);
    op_chk("mod_m7_2",   INT_MOD,  32'hFFFFFFF9, 32'h2,        34, 32'hFFFFFFFF, 1'b0);
    op_chk("divu_100_7", INT_DIVU, 32'd100,      32'd7,        34, 32'd14,       1'b0);
    op_chk("modu_100_7", INT_MODU, 32'd100,      32'd7,        34, 32'd2,        1'b0);
    op_chk("div_by0",    INT_DIV,  32'd5,        32'd0,        1,  32'hFFFFFFFF, 1'b1);
    op_chk("div_min_m1", INT_DIV,  32'h80000000, 32'hFFFFFFFF, 34, 32'h80000000, 1'b0);
    op_chk("mod_min_m1", INT_MOD,  32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 1'b0);
    op_chk("divu_max",   INT_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'h00000001, 1'b0);
`else
    op_chk("div_nodiv",  INT_DIV,  32'hFFFFFFF9, 32'h2,  1, 32'h0, 1'b1);
    op_chk("modu_nodiv", INT_MODU, 32'd100,      32'd7,  1, 32'h0, 1'b1);
    op_chk("div0_nodiv", INT_DIV,  32'd5,        32'd0,  1, 32'h0, 1'b1);
`endif

    // Start while busy and in DONE must be ignored
    @(negedge clk);
    func = INT_MUL; in1 = 32'h7; in2 = 32'hFFFFFFFD; start = 1'b1;
    @(posedge clk);
    pulses = 0; lat = 0; res_at_done = '0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start = (n == 5) || (n == 20);
      func = INT_EXTB; in1 = 32'h00000080; in2 = 32'h0;
      if (done) begin
        pulses++;
        if (lat == 0) begin
          lat = n;
          res_at_done = out;
          start = 1'b1;
        end
      end
      if (n == lat + 1 && lat != 0) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("busy_start_pulses", 64'(pulses), 64'd1);
    chk("busy_start_lat",    64'(lat),    64'd34);
    chk("busy_start_out",    64'(res_at_done), 64'hFFFFFFEB);
    chk("busy_start_hold",   64'(out),    64'hFFFFFFEB);
    chk("busy_start_idle",   64'(busy),   64'h0);

    // Reset during RUN cycle 10
    @(negedge clk);
    func = INT_MULU; in1 = 32'h1234; in2 = 32'h5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'h1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'h0);
    chk("rst_mid_out",  64'(out),  64'h0);
    chk("rst_mid_done", 64'(done), 64'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    func = INT_MULU; in1 = 32'd3; in2 = 32'd5; start = 1'b1;
    @(posedge clk);
    pulses = 0; lat = 0; res_at_done = '0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        pulses++;
        if (lat == 0) begin
          lat = n;
          res_at_done = out;
        end
      end
    end
    chk("post_rst_pulses", 64'(pulses), 64'd1);
    chk("post_rst_lat",    64'(lat),    64'd34);
    chk("post_rst_mulu",   64'(res_at_done), 64'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bexkat1_intseq.md
BEXKAT1_INTSEQ -- requirements
Module: bexkat1_intseq

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal values are 8 to 64, even.
REQ-002 Parameter FAST_EXT, default 1: when 1, INT_EXT, INT_EXTB, INT_COM and INT_NEG complete in the single-cycle path; when 0, they use the iterative path.
REQ-003 clk_i, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 start_i, input, 1 bit: operation request; sampled only in IDLE.
REQ-006 func_i, input, 4 bits: operation code of type intfunc_t.
REQ-007 in1_i, input, WIDTH bits: first operand (multiplicand or dividend).
REQ-008 in2_i, input, WIDTH bits: second operand (multiplier or divisor).
REQ-009 out_o, output, WIDTH bits: result register; holds its value until the next accepted start.
REQ-010 busy_o, output, 1 bit: high whenever state is not IDLE.
REQ-011 done_o, output, 1 bit: one-cycle pulse marking that out_o and err_o are valid.
REQ-012 err_o, output, 1 bit: divide-by-zero or unsupported function; valid with done_o and held until the next start.

Function
REQ-013 States are IDLE, RUN, FIX and DONE.
REQ-014 Transitions:
- IDLE to RUN on start_i for an iterative op.
- IDLE to DONE on start_i for a single-cycle op.
- RUN to FIX when the bit counter reaches 0.
- FIX to DONE.
- DONE to IDLE.
REQ-015 On start, operands and func_i are latched; later input changes have no effect until the next start.
REQ-016 start_i outside IDLE is ignored (no queueing); start_i in the DONE cycle is also ignored.
REQ-017 Single-cycle ops (EXT, EXTB, COM, NEG) have done_o high exactly 1 cycle after the start edge:
- EXT: sign-extend bits 15:0.
- EXTB: sign-extend bits 7:0.
- COM: bitwise invert.
- NEG: two's complement.
REQ-018 Iterative ops (MUL, MULU, MULX, MULUX, DIV, DIVU, MOD, MODU) run WIDTH RUN cycles plus 1 FIX cycle; done_o is high exactly WIDTH+2 cycles after the start edge.
REQ-019 Multiply uses shift-add, one bit per cycle, into a 2*WIDTH product.
- MUL and MULU return the low WIDTH bits.
- MULX returns the signed high WIDTH bits; MULUX returns the unsigned high WIDTH bits.
REQ-020 Divide uses restoring shift-subtract, one quotient bit per cycle.
- DIV and DIVU return the quotient; MOD and MODU return the remainder.
REQ-021 Signed ops operate on magnitudes; FIX then applies sign:
- Product and quotient are negative when the operand signs differ.
- Remainder takes the dividend's sign.
- Quotient truncates toward zero.
REQ-022 Signed DIV of MIN by -1 returns MIN (wraps) with err_o=0; MOD of MIN by -1 returns 0.
REQ-023 Divisor of 0 for any divide or mod op skips RUN:
- done_o is high 1 cycle after start.
- err_o=1 and out_o is all ones.
REQ-024 func_i codes outside intfunc_t complete in 1 cycle with err_o=1 and out_o=0.
REQ-025 All arithmetic is modulo 2^WIDTH, except for the 2*WIDTH product accumulator.

Reset
REQ-026 When rst_i is asserted at any time, including mid-operation, the block SHALL:
- go to IDLE;
- set out_o=0, busy_o=0, done_o=0 and err_o=0;
- clear the counter and accumulators;
- discard any in-flight operation without producing done_o.
REQ-027 In the first clock after rst_i deasserts, start_i SHALL be accepted.

Configuration
REQ-028 The macro BEXKAT1_INTSEQ_DIV_EN controls the divider.
- Defined: the divider is present and DIV, DIVU, MOD and MODU behave per REQ-020 to REQ-023.
- Undefined: no divider logic is built, and those four codes behave as unsupported per REQ-024.

Structure
REQ-029 The shared package bexkat1Def SHALL hold:
- the intfunc_t enum;
- a new intseq_state_t enum {IDLE, RUN, FIX, DONE}.
The module imports both and declares no local duplicates.
REQ-030 The counter width SHALL be $clog2(WIDTH)+1.
REQ-031 One sub-module, bexkat1_intseq_step, SHALL be used: a combinational single-iteration add/subtract-shift datapath, instantiated once; all control stays in the parent.

Verification
REQ-032 With WIDTH=32, MUL 7 by 0xFFFFFFFD SHALL give out_o 0xFFFFFFEB and done_o exactly 34 cycles after start.
REQ-033 MULUX 0xFFFFFFFF by 0xFFFFFFFF SHALL give 0xFFFFFFFE; MULX of the same operands SHALL give 0x00000000.
REQ-034 DIV 0xFFFFFFF9 by 2 SHALL give 0xFFFFFFFD; MOD of the same operands SHALL give 0xFFFFFFFF; DIVU 100 by 7 SHALL give 14; MODU 100 by 7 SHALL give 2.
REQ-035 DIV 5 by 0 SHALL give done_o at 1 cycle, err_o=1 and out_o=0xFFFFFFFF; DIV 0x80000000 by 0xFFFFFFFF SHALL give 0x80000000 with err_o=0.
REQ-036 EXTB 0x00000080 SHALL give 0xFFFFFF80 with done_o at 1 cycle; a second start_i pulsed while busy SHALL cause neither a second done_o nor a change in result.
REQ-037 Asserting rst_i at RUN cycle 10 SHALL cause:
- busy_o=0 and out_o=0 immediately;
- no done_o;
- a new MULU 3 by 5 started after reset returning 15.
